// File: rtl/sdram_linefill_if.sv
// sdram_linefill_if
//   Groups the line-fill request, SDRAM read-beat stream and line-buffer
//   write port used by sdram_linefill.
//   master : requester / SDRAM datapath side (drives start, start_word,
//            rd_valid, rd_data; observes buffer port and status)
//   slave  : sdram_linefill itself
//   Signals:
//     start, start_word     fill request and critical word index
//     rd_valid, rd_data     16-bit SDRAM read beats
//     buf_addr/buf_we/buf_di  line-buffer write port (word address, byte enables, data)
//     busy, done, word_valid, err  fill status
interface sdram_linefill_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                         start;
  logic [ADDR_WIDTH-1:0]        start_word;
  logic                         rd_valid;
  logic [15:0]                  rd_data;
  logic [ADDR_WIDTH-1:0]        buf_addr;
  logic [3:0]                   buf_we;
  logic [31:0]                  buf_di;
  logic                         busy;
  logic                         done;
  logic [(1<<ADDR_WIDTH)-1:0]   word_valid;
  logic                         err;

  modport master (
    output start, start_word, rd_valid, rd_data,
    input  buf_addr, buf_we, buf_di, busy, done, word_valid, err
  );

  modport slave (
    input  start, start_word, rd_valid, rd_data,
    output buf_addr, buf_we, buf_di, busy, done, word_valid, err
  );
endinterface

// File: rtl/sdram_linefill.sv
// sdram_linefill
//   SDRAM-side writer for the controller's line buffer. Packs a burst of
//   16-bit read beats (big-endian within a word) into 32-bit buffer writes,
//   starting at the critical word and wrapping around the line, and keeps a
//   per-word valid bitmap so the bus side can return the critical word early.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    sdram_linefill_if.slave (start/start_word, rd_valid/rd_data,
//            buf_addr/buf_we/buf_di, busy, done, word_valid, err)
//
//   Build option:
//     SDRAM_LINEFILL_TIMEOUT_EN  when defined, an 8-bit idle counter aborts
//     a stalled fill after 255 cycles without a beat (err set, no done).
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; any rd_valid here is excess data (err)
//   FILL  | accepting beats; final write cycle tracked by last_q
//   DONE  | one-cycle completion: done=1, busy=1, word_valid all ones
module sdram_linefill #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  sdram_linefill_if.slave  bus
);

  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_BEAT = {(ADDR_WIDTH+1){1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]            buf_we_q, buf_we_d;
  logic [31:0]           buf_di_q, buf_di_d;
  logic [WORDS-1:0]      word_valid_q, word_valid_d;
  logic                  err_q, err_d;
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
  logic [7:0]            idle_cnt_q, idle_cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      beat_cnt_q   <= '0;
      last_q       <= 1'b0;
      buf_addr_q   <= '0;
      buf_we_q     <= '0;
      buf_di_q     <= '0;
      word_valid_q <= '0;
      err_q        <= 1'b0;
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      last_q       <= last_d;
      buf_addr_q   <= buf_addr_d;
      buf_we_q     <= buf_we_d;
      buf_di_q     <= buf_di_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    beat_cnt_d   = beat_cnt_q;
    last_d       = last_q;
    buf_addr_d   = buf_addr_q;
    buf_we_d     = '0;
    buf_di_d     = '0;
    word_valid_d = word_valid_q;
    err_d        = err_q;
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
`endif

    // A word becomes valid at the edge that ends its low-half write cycle,
    // i.e. when the buffer has captured both halves.
    if (buf_we_q == 4'b0011) begin
      word_valid_d[buf_addr_q] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A beat arriving together with start is dropped; the start
          // clears the error it would otherwise raise.
          state_d      = FILL;
          ptr_d        = bus.start_word;
          beat_cnt_d   = '0;
          last_d       = 1'b0;
          word_valid_d = '0;
          err_d        = 1'b0;
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
          idle_cnt_d   = '0;
`endif
        end else if (bus.rd_valid) begin
          err_d = 1'b1;
        end
      end

      FILL: begin
        if (last_q) begin
          // Final write cycle in flight; nothing more belongs to this line.
          state_d = DONE;
          last_d  = 1'b0;
          if (bus.rd_valid) begin
            err_d = 1'b1;
          end
        end else if (bus.rd_valid) begin
          buf_addr_d = ptr_q;
          if (beat_cnt_q[0]) begin
            buf_we_d = 4'b0011;
            buf_di_d = {16'h0000, bus.rd_data};
            ptr_d    = ptr_q + 1'b1;
          end else begin
            buf_we_d = 4'b1100;
            buf_di_d = {bus.rd_data, 16'h0000};
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            last_d = 1'b1;
          end
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end else begin
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
          // The 255th consecutive idle cycle aborts the fill.
          if (idle_cnt_q == 8'd254) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        if (bus.rd_valid) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.buf_addr   = buf_addr_q;
  assign bus.buf_we     = buf_we_q;
  assign bus.buf_di     = buf_di_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.word_valid = word_valid_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_sdram_linefill.sv
module tb_sdram_linefill;

  logic clk;
  logic rst_n;

  sdram_linefill_if #(.ADDR_WIDTH(3)) bus ();

  sdram_linefill #(.ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;

  logic        mon_en;
  logic [7:0]  exp_wv;
  logic [38:0] exp_q[$];   // {addr[2:0], we[3:0], di[31:0]}
  logic [31:0] mem [0:7];  // buffer image built from observed writes

  // Write scoreboard and word_valid model, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_total++;
      if (bus.word_valid !== exp_wv)
        $display("FAIL word_valid: got %b expected %b at %0t", bus.word_valid, exp_wv, $time);
      else
        n_pass++;
      if (bus.buf_we !== 4'b0000) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: addr %0d we %b di %h at %0t",
                   bus.buf_addr, bus.buf_we, bus.buf_di, $time);
        end else begin
          logic [38:0] e;
          e = exp_q.pop_front();
          if ({bus.buf_addr, bus.buf_we, bus.buf_di} !== e)
            $display("FAIL write: got addr %0d we %b di %h expected addr %0d we %b di %h at %0t",
                     bus.buf_addr, bus.buf_we, bus.buf_di, e[38:36], e[35:32], e[31:0], $time);
          else
            n_pass++;
          if (e[35:32] == 4'b0011) exp_wv[e[38:36]] = 1'b1;
        end
        if (bus.buf_we[3]) mem[bus.buf_addr][31:24] = bus.buf_di[31:24];
        if (bus.buf_we[2]) mem[bus.buf_addr][23:16] = bus.buf_di[23:16];
        if (bus.buf_we[1]) mem[bus.buf_addr][15:8]  = bus.buf_di[15:8];
        if (bus.buf_we[0]) mem[bus.buf_addr][7:0]   = bus.buf_di[7:0];
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  // Drives a full 16-beat fill; gap idle cycles follow every beat but the last.
  // Returns 2ns after the edge that accepts the final beat.
  task automatic run_fill(input logic [2:0] sw, input logic [15:0] base,
                          input int gap, input int mid_start);
    logic [2:0]  p;
    logic [15:0] d;
    p = sw;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.start_word = sw;
    @(posedge clk); #2;
    bus.start = 1'b0;
    exp_wv = 8'h00;
    for (int b = 0; b < 16; b++) begin
      d = base + 16'(b);
      bus.rd_valid = 1'b1;
      bus.rd_data  = d;
      bus.start    = (b == mid_start);
      bus.start_word = 3'd5;
      if (b % 2 == 1) begin
        exp_q.push_back({p, 4'b0011, 16'h0000, d});
        p = p + 3'd1;
      end else begin
        exp_q.push_back({p, 4'b1100, d, 16'h0000});
      end
      @(posedge clk); #2;
      bus.rd_valid = 1'b0;
      bus.start    = 1'b0;
      if (b != 15)
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #2;
        end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.start_word = '0; bus.rd_valid = 1'b0; bus.rd_data = '0;
    mon_en = 1'b0; exp_wv = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({bus.buf_addr, bus.buf_we, bus.buf_di, bus.busy, bus.done, bus.word_valid, bus.err} !== 49'h0)
      $display("FAIL reset_state: addr %0d we %b di %h busy %b done %b wv %b err %b",
               bus.buf_addr, bus.buf_we, bus.buf_di, bus.busy, bus.done, bus.word_valid, bus.err);
    else n_pass++;
    mon_en = 1'b1;
  endtask

  task automatic test_straight();
    int dc;
    dc = done_cnt;
    run_fill(3'd0, 16'h0000, 0, -1);
    n_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL straight_last_write: done %b busy %b expected 0 1", bus.done, bus.busy);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.word_valid !== 8'hFF)
      $display("FAIL straight_done: done %b busy %b wv %b expected 1 1 11111111",
               bus.done, bus.busy, bus.word_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL straight_idle: done %b busy %b err %b expected 0 0 0", bus.done, bus.busy, bus.err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mem[0] !== 32'h0000_0001 || mem[7] !== 32'h000E_000F)
      $display("FAIL straight_data: word0 %h word7 %h expected 00000001 000e000f", mem[0], mem[7]);
    else n_pass++;
    n_total++;
    if (done_cnt - dc !== 1 || exp_q.size() != 0)
      $display("FAIL straight_done_count: pulses %0d pending %0d expected 1 0", done_cnt - dc, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    run_fill(3'd6, 16'h0100, 0, -1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (mem[6] !== 32'h0100_0101 || mem[7] !== 32'h0102_0103 ||
        mem[0] !== 32'h0104_0105 || mem[5] !== 32'h010E_010F)
      $display("FAIL wrap_data: w6 %h w7 %h w0 %h w5 %h expected 01000101 01020103 01040105 010e010f",
               mem[6], mem[7], mem[0], mem[5]);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL wrap_end: busy %b pending %0d expected 0 0", bus.busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_gapped();
    int dc;
    logic [31:0] w;
    dc = done_cnt;
    run_fill(3'd0, 16'h0000, 2, -1);
    n_total++;
    if (bus.done !== 1'b0)
      $display("FAIL gap_early_done: done %b expected 0", bus.done);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b1)
      $display("FAIL gap_done: done %b expected 1", bus.done);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      w = {16'(2*i), 16'(2*i+1)};
      n_total++;
      if (mem[i] !== w)
        $display("FAIL gap_data: word%0d got %h expected %h", i, mem[i], w);
      else n_pass++;
    end
    n_total++;
    if (done_cnt - dc !== 1 || bus.busy !== 1'b0)
      $display("FAIL gap_done_count: pulses %0d busy %b expected 1 0", done_cnt - dc, bus.busy);
    else n_pass++;
  endtask

  task automatic test_errors();
    int dc;
    // stray beat in IDLE
    @(posedge clk); #2;
    bus.rd_valid = 1'b1; bus.rd_data = 16'hBAD0;
    @(posedge clk); #2;
    bus.rd_valid = 1'b0;
    n_total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL stray_err: err %b busy %b expected 1 0", bus.err, bus.busy);
    else n_pass++;
    @(posedge clk); #2;
    n_total++;
    if (bus.err !== 1'b1)
      $display("FAIL err_sticky: err %b expected 1", bus.err);
    else n_pass++;
    // start with a simultaneous beat: beat dropped, err cleared
    bus.start = 1'b1; bus.start_word = 3'd3; bus.rd_valid = 1'b1; bus.rd_data = 16'hBAD1;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.rd_valid = 1'b0;
    exp_wv = 8'h00;
    n_total++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL start_clears_err: err %b busy %b expected 0 1", bus.err, bus.busy);
    else n_pass++;
    // finish that fill from a separate start-free path is not possible; abort via reset-free
    // completion: feed 16 beats directly (word pointer starts at 3)
    begin
      logic [2:0] p;
      p = 3'd3;
      for (int b = 0; b < 16; b++) begin
        bus.rd_valid = 1'b1; bus.rd_data = 16'h0300 + 16'(b);
        bus.start = (b == 5); bus.start_word = 3'd6;
        if (b % 2 == 1) begin
          exp_q.push_back({p, 4'b0011, 16'h0000, bus.rd_data});
          p = p + 3'd1;
        end else begin
          exp_q.push_back({p, 4'b1100, bus.rd_data, 16'h0000});
        end
        @(posedge clk); #2;
        bus.rd_valid = 1'b0; bus.start = 1'b0;
      end
    end
    dc = done_cnt;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0)
      $display("FAIL midstart_done: done %b err %b expected 1 0", bus.done, bus.err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mem[3] !== 32'h0300_0301 || mem[2] !== 32'h030E_030F || exp_q.size() != 0)
      $display("FAIL midstart_data: w3 %h w2 %h pending %0d expected 03000301 030e030f 0",
               mem[3], mem[2], exp_q.size());
    else n_pass++;
    // full run with mid-FILL start via driver as well
    run_fill(3'd4, 16'h0400, 0, 9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (mem[4] !== 32'h0400_0401 || mem[3] !== 32'h040E_040F || bus.err !== 1'b0 || done_cnt - dc !== 2)
      $display("FAIL midstart_run: w4 %h w3 %h err %b pulses %0d expected 04000401 040e040f 0 2",
               mem[4], mem[3], bus.err, done_cnt - dc);
    else n_pass++;
  endtask

  task automatic test_reset_midfill();
    @(posedge clk); #2;
    bus.start = 1'b1; bus.start_word = 3'd4;
    @(posedge clk); #2;
    bus.start = 1'b0;
    exp_wv = 8'h00;
    for (int b = 0; b < 6; b++) begin
      bus.rd_valid = 1'b1; bus.rd_data = 16'h0500 + 16'(b);
      if (b % 2 == 1) exp_q.push_back({3'(4 + b/2), 4'b0011, 16'h0000, bus.rd_data});
      else            exp_q.push_back({3'(4 + b/2), 4'b1100, bus.rd_data, 16'h0000});
      @(posedge clk); #2;
      bus.rd_valid = 1'b0;
    end
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_total++;
    if ({bus.buf_addr, bus.buf_we, bus.buf_di, bus.busy, bus.done, bus.word_valid, bus.err} !== 49'h0)
      $display("FAIL async_reset: addr %0d we %b di %h busy %b done %b wv %b err %b",
               bus.buf_addr, bus.buf_we, bus.buf_di, bus.busy, bus.done, bus.word_valid, bus.err);
    else n_pass++;
    exp_q.delete();
    exp_wv = 8'h00;
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_fill(3'd1, 16'h2000, 1, -1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  wi;
      logic [31:0] w;
      wi = 3'(i);
      w  = {16'h2000 + 16'(2*((i - 1 + 8) % 8)), 16'h2001 + 16'(2*((i - 1 + 8) % 8))};
      n_total++;
      if (mem[wi] !== w)
        $display("FAIL post_reset_data: word%0d got %h expected %h", i, mem[wi], w);
      else n_pass++;
    end
  endtask

`ifdef SDRAM_LINEFILL_TIMEOUT_EN
  task automatic test_timeout();
    int dc;
    int n;
    dc = done_cnt;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.start_word = 3'd0;
    @(posedge clk); #2;
    bus.start = 1'b0;
    exp_wv = 8'h00;
    for (int b = 0; b < 3; b++) begin
      bus.rd_valid = 1'b1; bus.rd_data = 16'h0700 + 16'(b);
      if (b % 2 == 1) exp_q.push_back({3'(b/2), 4'b0011, 16'h0000, bus.rd_data});
      else            exp_q.push_back({3'(b/2), 4'b1100, bus.rd_data, 16'h0000});
      @(posedge clk); #2;
      bus.rd_valid = 1'b0;
    end
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      n = i;
      if (bus.busy !== 1'b1) break;
    end
    n_total++;
    if (n != 255 || bus.busy !== 1'b0)
      $display("FAIL timeout_cycles: aborted after %0d busy %b expected 255 0", n, bus.busy);
    else n_pass++;
    n_total++;
    if (bus.err !== 1'b1 || bus.word_valid !== 8'b0000_0001 || done_cnt != dc)
      $display("FAIL timeout_state: err %b wv %b pulses %0d expected 1 00000001 0",
               bus.err, bus.word_valid, done_cnt - dc);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_straight();
    test_wrap();
    test_gapped();
    test_errors();
    test_reset_midfill();
`ifdef SDRAM_LINEFILL_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
